// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 3-sample majority per bit, optional parity, break
// detection and a single-entry valid/ready output holding register with overrun.
module uart_rx_os #(
    parameter int unsigned CLK_DIV    = 27,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = 4;
    localparam int unsigned MID   = OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0]     clk_cnt;
    logic [OS_W-1:0]      os_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 s0, s1;
    logic [DATA_BITS-1:0] data_sr;
    logic                 par_bit, any_one, stop_err, first_stop_zero;

    logic tick_c, start_c, maj_c, dec_c, done_c, ferr_c, brk_c, perr_c, par_exp_c, accept_c;

    always_comb begin
        tick_c    = (clk_cnt == CNT_W'(CLK_DIV - 1));
        start_c   = (state_q == S_IDLE) && rx_prev && !rx_sync;
        maj_c     = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
        dec_c     = tick_c && (os_cnt == OS_W'(MID + 1)) &&
                    (state_q inside {S_START, S_DATA, S_PARITY, S_STOP});
        done_c    = dec_c && (state_q == S_STOP) && (bit_cnt == BIT_W'(STOP_BITS - 1));
        ferr_c    = stop_err | ~maj_c;
        // With one stop bit the live decision is the first stop bit.
        brk_c     = ~any_one & ((bit_cnt == BIT_W'(0)) ? ~maj_c : first_stop_zero);
        par_exp_c = (PARITY == 1) ? ~^data_sr : ^data_sr;
        perr_c    = (PARITY != 0) && (par_bit != par_exp_c);
        accept_c  = valid & ready;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start_c) state_d = S_START;
            S_START:     if (dec_c) state_d = maj_c ? S_IDLE : S_DATA;
            S_DATA:      if (dec_c && bit_cnt == BIT_W'(DATA_BITS - 1))
                             state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY:    if (dec_c) state_d = S_STOP;
            S_STOP:      if (done_c) state_d = ferr_c ? S_WAIT_IDLE : S_IDLE;
            S_WAIT_IDLE: if (rx_sync) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != S_IDLE);
            if (state_d != state_q) bit_cnt <= '0;
            else if (dec_c)         bit_cnt <= bit_cnt + BIT_W'(1);
        end
    end

    // Synchronizer, edge history and tick/oversample counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            clk_cnt <= '0;
            os_cnt  <= '0;
            s0      <= 1'b1;
            s1      <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (start_c) begin
                clk_cnt <= '0;
                os_cnt  <= '0;
            end else if (tick_c) begin
                clk_cnt <= '0;
                os_cnt  <= (os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt + OS_W'(1);
                if (os_cnt == OS_W'(MID - 1)) s0 <= rx_sync;
                if (os_cnt == OS_W'(MID))     s1 <= rx_sync;
            end else begin
                clk_cnt <= clk_cnt + CNT_W'(1);
            end
        end
    end

    // Per-frame accumulation of data, parity and stop-bit status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sr         <= '0;
            par_bit         <= 1'b0;
            any_one         <= 1'b0;
            stop_err        <= 1'b0;
            first_stop_zero <= 1'b0;
        end else if (start_c) begin
            any_one         <= 1'b0;
            stop_err        <= 1'b0;
            first_stop_zero <= 1'b0;
        end else if (dec_c) begin
            case (state_q)
                S_DATA: begin
                    data_sr <= {maj_c, data_sr[DATA_BITS-1:1]};
                    any_one <= any_one | maj_c;
                end
                S_PARITY: begin
                    par_bit <= maj_c;
                    any_one <= any_one | maj_c;
                end
                S_STOP: begin
                    if (!maj_c) stop_err <= 1'b1;
                    if (bit_cnt == BIT_W'(0)) first_stop_zero <= ~maj_c;
                end
                default: ;
            endcase
        end
    end

    // Output holding register: accept wins over overrun on a coincident completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else if (done_c) begin
            if (!valid || accept_c) begin
                data_out   <= data_sr;
                parity_err <= perr_c;
                frame_err  <= ferr_c;
                break_det  <= brk_c;
                valid      <= 1'b1;
                overrun    <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (accept_c) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule
